// File: rtl/fp_add_sub.sv
// Multi-cycle IEEE-754 single-precision adder: flush-to-zero inputs/outputs,
// round to nearest even, result and done held until the next request.
module fp_add_sub (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic        start,
  output logic [31:0] result,
  output logic        done
);

  localparam int unsigned WW = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 24;
  localparam int unsigned GW = MW + 3;
  localparam int unsigned SW = GW + 1;
  localparam int unsigned XW = EW + 1;
  localparam int unsigned LW = 5;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t state_q, state_d;
  logic   rph_q;

  logic [WW-1:0] ra_q, rb_q;
  logic          sa_q, sb_q;
  logic [EW-1:0] ea_q, eb_q;
  logic [MW-1:0] ma_q, mb_q;
  logic          spec_q;
  logic [WW-1:0] spec_val_q;
  logic          sx_q, sub_q;
  logic [EW-1:0] ex_q;
  logic [GW-1:0] mx_q, my_q;
  logic [SW-1:0] sum_q;
  logic          sn_q, zr_q;
  logic [XW-1:0] en_q;
  logic [GW-1:0] mn_q;
  logic [MW:0]   mr_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = UNPACK;
      UNPACK:  state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   if (rph_q) state_d = DONE;
      DONE:    if (start) state_d = UNPACK;
      default: state_d = IDLE;
    endcase
  end

  // Unpack: field split and NaN/infinity screening
  logic [EW-1:0]   exp_a_c, exp_b_c;
  logic            nan_a_c, nan_b_c, inf_a_c, inf_b_c, spec_c;
  logic [WW-1:0]   spec_val_c;

  always_comb begin
    exp_a_c    = ra_q[30:23];
    exp_b_c    = rb_q[30:23];
    nan_a_c    = (&exp_a_c) && (|ra_q[22:0]);
    nan_b_c    = (&exp_b_c) && (|rb_q[22:0]);
    inf_a_c    = (&exp_a_c) && !(|ra_q[22:0]);
    inf_b_c    = (&exp_b_c) && !(|rb_q[22:0]);
    spec_c     = nan_a_c || nan_b_c || inf_a_c || inf_b_c;
    spec_val_c = rb_q;
    if (nan_a_c || nan_b_c || (inf_a_c && inf_b_c && (ra_q[31] ^ rb_q[31])))
      spec_val_c = 32'h7FC0_0000;
    else if (inf_a_c)
      spec_val_c = ra_q;
  end

  // Align: order by magnitude, shift the smaller with guard/round/sticky
  logic          a_big_c, s_big_c;
  logic [EW-1:0] e_big_c, e_sml_c, diff_c;
  logic [MW-1:0] m_big_c, m_sml_c;
  logic [52:0]   wide_c;
  logic [GW-1:0] al_c;

  always_comb begin
    a_big_c = {ea_q, ma_q} >= {eb_q, mb_q};
    s_big_c = a_big_c ? sa_q : sb_q;
    e_big_c = a_big_c ? ea_q : eb_q;
    e_sml_c = a_big_c ? eb_q : ea_q;
    m_big_c = a_big_c ? ma_q : mb_q;
    m_sml_c = a_big_c ? mb_q : ma_q;
    diff_c  = e_big_c - e_sml_c;
    wide_c  = {m_sml_c, 29'b0} >> diff_c;
    al_c    = {wide_c[52:27], wide_c[26] | (|wide_c[25:0])};
    if (diff_c >= 8'd26)
      al_c = {26'b0, |m_sml_c};
  end

  // Add/subtract magnitudes; mx is never smaller than my
  logic [SW-1:0] sum_c;

  always_comb begin
    if (sub_q) sum_c = {1'b0, mx_q} - {1'b0, my_q};
    else       sum_c = {1'b0, mx_q} + {1'b0, my_q};
  end

  // Normalise: carry right-shift, or leading-zero left-shift with underflow flush
  logic [LW-1:0] lz_c;
  logic [GW-1:0] mn_c;
  logic [XW-1:0] en_c;
  logic          zr_c, sn_c;

  always_comb begin
    lz_c = '0;
    for (int i = 0; i < 27; i++)
      if (sum_q[i]) lz_c = LW'(26 - i);
    mn_c = sum_q[GW-1:0] << lz_c;
    en_c = {1'b0, ex_q} - {4'b0, lz_c};
    zr_c = 1'b0;
    sn_c = sx_q;
    if (sum_q[SW-1]) begin
      mn_c = {sum_q[27:2], sum_q[1] | sum_q[0]};
      en_c = {1'b0, ex_q} + 9'd1;
    end else if (sum_q == '0) begin
      zr_c = 1'b1;
      sn_c = sx_q & ~sub_q;
    end else if ({1'b0, ex_q} <= {4'b0, lz_c}) begin
      zr_c = 1'b1;
    end
  end

  // Round to nearest even, then renormalise and pack
  logic          inc_c;
  logic [MW:0]   mr_c;
  logic [XW-1:0] e_fin_c;
  logic [22:0]   frac_c;
  logic [WW-1:0] res_c;

  always_comb begin
    inc_c   = mn_q[2] & (mn_q[3] | mn_q[1] | mn_q[0]);
    mr_c    = {1'b0, mn_q[26:3]} + 25'(inc_c);
    e_fin_c = en_q + {8'b0, mr_q[MW]};
    frac_c  = mr_q[MW] ? mr_q[23:1] : mr_q[22:0];
    res_c   = {sn_q, e_fin_c[7:0], frac_c};
    if (spec_q)
      res_c = spec_val_q;
    else if (zr_q)
      res_c = {sn_q, 31'b0};
    else if (e_fin_c >= 9'd255)
      res_c = {sn_q, 8'hFF, 23'b0};
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rph_q      <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      sx_q       <= 1'b0;
      sub_q      <= 1'b0;
      ex_q       <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      sum_q      <= '0;
      sn_q       <= 1'b0;
      zr_q       <= 1'b0;
      en_q       <= '0;
      mn_q       <= '0;
      mr_q       <= '0;
      result     <= '0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      rph_q   <= (state_q == ROUND) ? ~rph_q : 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            ra_q <= a1;
            rb_q <= a2;
            done <= 1'b0;
          end
        end
        UNPACK: begin
          sa_q       <= ra_q[31];
          sb_q       <= rb_q[31];
          ea_q       <= exp_a_c;
          eb_q       <= exp_b_c;
          ma_q       <= (exp_a_c == '0) ? '0 : {1'b1, ra_q[22:0]};
          mb_q       <= (exp_b_c == '0) ? '0 : {1'b1, rb_q[22:0]};
          spec_q     <= spec_c;
          spec_val_q <= spec_val_c;
        end
        ALIGN: begin
          sx_q  <= s_big_c;
          sub_q <= sa_q ^ sb_q;
          ex_q  <= e_big_c;
          mx_q  <= {m_big_c, 3'b000};
          my_q  <= al_c;
        end
        ADD: sum_q <= sum_c;
        NORM: begin
          mn_q <= mn_c;
          en_q <= en_c;
          zr_q <= zr_c;
          sn_q <= sn_c;
        end
        ROUND: begin
          if (!rph_q) begin
            mr_q <= mr_c;
          end else begin
            result <= res_c;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Self-checking bench for fp_add_sub: directed corner cases, reset behaviour
// and randomised operands against a real-arithmetic reference model.
module tb_fp_add_sub;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a1, a2;
  logic        start;
  logic [31:0] result;
  logic        done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] last_exp;

  fp_add_sub dut (
    .clk    (clk),
    .reset  (reset),
    .a1     (a1),
    .a2     (a2),
    .start  (start),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Single-precision operand as a double, with exponent-0 inputs flushed to signed zero
  function automatic real to_real(input logic [31:0] x);
    if (x[30:23] == 8'd0)
      return $bitstoreal({x[31], 63'b0});
    return $bitstoreal({x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'b0});
  endfunction

  // Reference: exact-enough double sum, then round-to-nearest-even to single
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic        nan_a, nan_b, inf_a, inf_b, up;
    logic [63:0] d;
    int          e;
    logic [23:0] keep;
    logic [28:0] rem;
    logic [24:0] k25;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (nan_a || nan_b) return 32'h7FC0_0000;
    if (inf_a && inf_b) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
    if (inf_a) return a;
    if (inf_b) return b;
    d = $realtobits(to_real(a) + to_real(b));
    if (d[62:0] == 0) return {d[63], 31'b0};
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0) return {d[63], 31'b0};
    keep = {1'b1, d[51:29]};
    rem  = d[28:0];
    up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    k25  = {1'b0, keep} + 25'(up);
    if (k25[24]) e++;
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], 8'(e), k25[22:0]};
  endfunction

  // One request: latency, held result, scrambled operands after capture
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    a1 = a;
    a2 = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a1 = $urandom;
    a2 = $urandom;
    chk({tag, "_clr"}, 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_early"}, {31'b0, done}, 32'd0);
    chk({tag, "_prev"}, result, last_exp);
    @(posedge clk); #1;
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_res"}, result, exp);
    last_exp = exp;
  endtask

  function automatic logic [31:0] rand_op(input logic [31:0] a);
    logic [31:0] r;
    int          ea;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: ;
      1: begin
        ea = int'(a[30:23]) + $urandom_range(0, 6) - 3;
        if (ea < 1) ea = 1;
        if (ea > 254) ea = 254;
        r[30:23] = 8'(ea);
      end
      2: r = a ^ 32'h8000_0000 ^ ($urandom & 32'h0000_00FF);
      3: r[30:23] = (($urandom & 1) != 0) ? 8'h00 : 8'hFF;
      default: r = a ^ 32'h8000_0000;
    endcase
    if ($urandom_range(0, 15) == 0) r[22:0] = '0;
    return r;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    int          bad;
    reset = 1'b1;
    start = 1'b0;
    a1 = '0;
    a2 = '0;
    last_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    reset = 1'b0;

    run_op("add", 32'h3FE0_0000, 32'h4050_0000, 32'h40A0_0000);
    run_op("align2", 32'h41CA_0000, 32'h40E1_0000, 32'h4201_2000);
    run_op("sub_pos", 32'h4050_0000, 32'hBFE0_0000, 32'h3FC0_0000);
    run_op("sub_neg", 32'hC050_0000, 32'h3FE0_0000, 32'hBFC0_0000);
    run_op("cancel", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    run_op("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    run_op("inf_nan", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_op("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run_op("inf_pass", 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000);
    run_op("zero_x", 32'h0000_0000, 32'hC120_0000, 32'hC120_0000);
    run_op("pz_mz", 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    run_op("mz_mz", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_op("denorm", 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
    run_op("tie_even", 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    run_op("tie_up", 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
    run_op("uflow", 32'h0080_0001, 32'h8080_0000, 32'h0000_0000);

    // Reset while the operation is in ALIGN
    a1 = 32'h3FE0_0000;
    a2 = 32'h4050_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_res", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_exp = '0;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done !== 1'b0) bad++;
    end
    chk("mid_rst_nodone", 32'(bad), 32'd0);

    // Held result while idling in DONE
    run_op("hold_op", 32'h41CA_0000, 32'h40E1_0000, 32'h4201_2000);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || result !== 32'h4201_2000) bad++;
    end
    chk("hold20", 32'(bad), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("hold_rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_exp = '0;

    for (int n = 0; n < 250; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:23] = 8'h00;
      rb = rand_op(ra);
      run_op($sformatf("rnd%0d_%08h_%08h", n, ra, rb), ra, rb, ref_add(ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_sub.md
FP_ADD_SUB -- requirements
Module: fp_add_sub

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports are named as below.
REQ-002 SHALL have these ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- a1  input  32  IEEE-754 single-precision operand A
- a2  input  32  IEEE-754 single-precision operand B
- start  input  1  one-cycle request pulse; operands are valid on that cycle
- result  output  32  IEEE-754 single-precision sum a1+a2
- done  output  1  high when result is valid
REQ-003 SHALL have no parameters.

Function
REQ-004 SHALL compute the signed sum a1+a2; subtraction is expressed through operand sign bits, and there is no op input.
REQ-005 SHALL implement the FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
REQ-006 IDLE: on a rising edge with start=1, SHALL capture a1 and a2 into internal registers and go to UNPACK; start=0 stays in IDLE.
REQ-007 SHALL ignore a1 and a2 after the capture edge; operand changes mid-operation have no effect.
REQ-008 UNPACK: SHALL split each operand into sign, 8-bit exponent and 24-bit significand, with the hidden 1 for exponent != 0.
REQ-009 UNPACK: SHALL treat exponent 0 (zero or denormal) as zero, i.e. flush to zero.
REQ-010 ALIGN: SHALL right-shift the smaller-exponent significand by the exponent difference, keeping guard, round and sticky bits.
REQ-011 ALIGN: a difference of 26 or more SHALL reduce that operand to sticky only.
REQ-012 ADD: equal signs SHALL add magnitudes; different signs SHALL subtract smaller from larger magnitude, and the result takes the larger operand's sign.
REQ-013 NORM: a carry-out SHALL right-shift by 1 and increment the exponent.
REQ-014 NORM: otherwise SHALL left-shift by the leading-zero count (single-cycle priority encoder) and decrement the exponent by that count.
REQ-015 NORM: an exponent that would fall to 0 or below SHALL flush the result to signed zero.
REQ-016 ROUND: SHALL round to nearest, ties to even, and renormalise on mantissa overflow.
REQ-017 ROUND: a final exponent of 255 or more SHALL produce signed infinity (exp=0xFF, mantissa 0).
REQ-018 An exact zero result from opposite-sign equal magnitudes SHALL be +0 (0x00000000).
REQ-019 Special inputs: any NaN operand SHALL give 0x7FC00000.
REQ-020 Special inputs: +inf plus -inf SHALL give 0x7FC00000.
REQ-021 Special inputs: a single infinity operand SHALL pass that infinity through.
REQ-022 Special inputs: zero + x SHALL give x; +0 + -0 SHALL give +0.
REQ-023 Latency: the start edge is edge k; result and done SHALL update at edge k+6 (DONE entered), so done first reads high after that edge.
REQ-024 DONE: done=1 and result SHALL be held stable indefinitely.
REQ-025 DONE: start=1 SHALL capture new operands, clear done on that edge and go to UNPACK; start SHALL be ignored in all states other than IDLE and DONE.
REQ-026 result SHALL change only on entry to DONE or on reset.

Reset
REQ-027 reset=1 SHALL immediately, independent of clk, force state=IDLE, done=0, result=0x00000000 and clear all internal registers.
REQ-028 Reset during any state SHALL abort the operation with no later done pulse.
REQ-029 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-030 a1=0x3FE00000 (1.75), a2=0x40500000 (3.25), pulse start -> done after 6 edges, result=0x40A00000 (5.0).
REQ-031 a1=0x41CA0000 (25.25), a2=0x40E10000 (7.03125) -> result=0x42012000 (32.28125), checking alignment across an exponent difference of 2.
REQ-032 a1=0x40500000 (3.25), a2=0xBFE00000 (-1.75) -> result=0x3FC00000 (1.5); a1=0xC0500000, a2=0x3FE00000 -> result=0xBFC00000 (-1.5).
REQ-033 a1=0x3F800000, a2=0xBF800000 -> result=0x00000000.
REQ-034 a1=0x7F7FFFFF, a2=0x7F7FFFFF -> result=0x7F800000.
REQ-035 a1=0x7F800000, a2=0xFF800000 -> result=0x7FC00000.
REQ-036 Assert reset during ALIGN -> done=0 and result=0 immediately, with no done afterwards.
REQ-037 Hold done high for 20 cycles -> result stable; after reset, done=0.
